// File: rtl/llc_arb_pkg.sv
// Shared types and helpers for the LLC host-port arbiter.
// Line geometry (PADDR_BITS, B) is fixed here because hc_req_t is shared by every user.
package llc_arb_pkg;
  localparam int NREQ_DEF        = 2;
  localparam int OUTSTANDING_DEF = 4;
  localparam int PADDR_BITS      = 19;
  localparam int B               = 64;
  localparam int LINE_W          = 8 * B;
  localparam int ID_W            = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;
  localparam int MAX_REQ         = 32;

  typedef struct packed {
    logic [PADDR_BITS-1:0] addr;
    logic                  we;
    logic [LINE_W-1:0]     line;
  } hc_req_t;

  typedef struct packed {
    logic               found;
    logic [4:0]         idx;
    logic [MAX_REQ-1:0] onehot;
  } rr_pick_t;

  // First set bit of valid searching ptr+1, ptr+2, ... mod n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [4:0] ptr, input int n);
    rr_pick_t p;
    int k;
    p = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        k = (int'(ptr) + i) % n;
        if (valid[k[4:0]]) begin
          p.found = 1'b1;
          p.idx   = k[4:0];
        end
      end
    end
    if (p.found) p.onehot[p.idx] = 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/llc_port_arbiter_if.sv
// Requester-side and LLC-side handshake bundle of the host-port arbiter.
// slave = arbiter view, master = requesters + LLC view.
interface llc_port_arbiter_if #(parameter int NREQ = llc_arb_pkg::NREQ_DEF);
  logic [NREQ-1:0]                               req_valid_in;
  logic [NREQ-1:0]                               req_ready_out;
  logic [NREQ-1:0][llc_arb_pkg::PADDR_BITS-1:0]  req_addr_in;
  logic [NREQ-1:0]                               req_we_in;
  logic [NREQ-1:0][llc_arb_pkg::LINE_W-1:0]      req_line_in;
  logic [NREQ-1:0]                               rsp_valid_out;
  logic [NREQ-1:0]                               rsp_ready_in;
  logic [llc_arb_pkg::PADDR_BITS-1:0]            rsp_addr_out;
  logic [llc_arb_pkg::LINE_W-1:0]                rsp_line_out;
  logic                                          lc_valid_out;
  logic                                          lc_ready_in;
  logic [llc_arb_pkg::PADDR_BITS-1:0]            lc_addr_out;
  logic                                          lc_we_out;
  logic [llc_arb_pkg::LINE_W-1:0]                lc_line_out;
  logic                                          lc_valid_in;
  logic                                          lc_ready_out;
  logic [llc_arb_pkg::PADDR_BITS-1:0]            lc_addr_in;
  logic [llc_arb_pkg::LINE_W-1:0]                lc_line_in;

  modport slave (
    input  req_valid_in, req_addr_in, req_we_in, req_line_in, rsp_ready_in,
           lc_ready_in, lc_valid_in, lc_addr_in, lc_line_in,
    output req_ready_out, rsp_valid_out, rsp_addr_out, rsp_line_out,
           lc_valid_out, lc_addr_out, lc_we_out, lc_line_out, lc_ready_out
  );

  modport master (
    output req_valid_in, req_addr_in, req_we_in, req_line_in, rsp_ready_in,
           lc_ready_in, lc_valid_in, lc_addr_in, lc_line_in,
    input  req_ready_out, rsp_valid_out, rsp_addr_out, rsp_line_out,
           lc_valid_out, lc_addr_out, lc_we_out, lc_line_out, lc_ready_out
  );
endinterface

// File: rtl/llc_arb_id_fifo.sv
// Requester-ID FIFO for in-flight reads; full/empty come from the registered count,
// so an entry freed by a pop is only reusable on the following cycle.
module llc_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/llc_port_arbiter.sv
// Round-robin share of the single LLC host port among NREQ upper caches, with in-order
// response routing. LLC_ARB_PERF_EN adds per-requester grant/stall counters.
module llc_port_arbiter
  import llc_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  llc_port_arbiter_if.slave  bus,
  output logic               err_out
`ifdef LLC_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0] grant_cnt_out,
  output logic [NREQ*32-1:0] stall_cnt_out
`endif
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  hc_req_t         slot;
  logic            slot_vld;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] elig;
  rr_pick_t        pick;
  logic [IDW-1:0]  win;
  logic            accept, push, pop;
  logic            fifo_full, fifo_empty;
  logic [IDW-1:0]  head;
  logic            unused_pick;

  // Reads need a free FIFO entry; writebacks never wait on it.
  assign elig        = bus.req_valid_in & (bus.req_we_in | {NREQ{!fifo_full}});
  assign pick        = rr_pick(MAX_REQ'(elig), 5'(rr_ptr), NREQ);
  assign win         = pick.idx[IDW-1:0];
  assign accept      = !rst_in && pick.found && (!slot_vld || bus.lc_ready_in);
  assign push        = accept && !bus.req_we_in[win];
  assign unused_pick = ^{pick.onehot[MAX_REQ-1:NREQ], pick.idx[4:IDW]};

  assign bus.req_ready_out = accept ? pick.onehot[NREQ-1:0] : '0;
  assign bus.lc_valid_out  = slot_vld;
  assign bus.lc_addr_out   = slot.addr;
  assign bus.lc_we_out     = slot.we;
  assign bus.lc_line_out   = slot.line;
  assign bus.rsp_addr_out  = bus.lc_addr_in;
  assign bus.rsp_line_out  = bus.lc_line_in;

  // Stray responses with no reader are drained so the LLC never wedges.
  always_comb begin
    bus.rsp_valid_out = '0;
    bus.lc_ready_out  = 1'b0;
    if (!rst_in) begin
      if (fifo_empty) begin
        bus.lc_ready_out = bus.lc_valid_in;
      end else begin
        bus.lc_ready_out        = bus.rsp_ready_in[head];
        bus.rsp_valid_out[head] = bus.lc_valid_in;
      end
    end
  end

  assign pop = bus.lc_valid_in && bus.lc_ready_out && !fifo_empty;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_vld <= 1'b0;
      slot     <= '0;
      rr_ptr   <= IDW'(NREQ - 1);
      err_out  <= 1'b0;
    end else begin
      if (accept) begin
        slot_vld <= 1'b1;
        slot     <= '{addr: bus.req_addr_in[win], we: bus.req_we_in[win],
                      line: bus.req_line_in[win]};
        rr_ptr   <= win;
      end else if (slot_vld && bus.lc_ready_in) begin
        slot_vld <= 1'b0;
      end
      if (bus.lc_valid_in && fifo_empty) err_out <= 1'b1;
    end
  end

  llc_arb_id_fifo #(.DEPTH(OUTSTANDING), .W(IDW)) u_id_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push),
    .pop   (pop),
    .din   (win),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

`ifdef LLC_ARB_PERF_EN
  logic [NREQ-1:0][31:0] grant_cnt, stall_cnt;
  assign grant_cnt_out = grant_cnt;
  assign stall_cnt_out = stall_cnt;

  for (genvar r = 0; r < NREQ; r++) begin : g_perf
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        grant_cnt[r] <= '0;
        stall_cnt[r] <= '0;
      end else begin
        if (bus.req_ready_out[r]) grant_cnt[r] <= grant_cnt[r] + 32'd1;
        if (bus.req_valid_in[r] && !bus.req_ready_out[r]) stall_cnt[r] <= stall_cnt[r] + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_llc_port_arbiter.sv
// Directed + random bench for llc_port_arbiter against a queue-based reference model.
module tb_llc_port_arbiter;
  import llc_arb_pkg::*;
  localparam int NR   = 2;
  localparam int OUTS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  always #5 clk = ~clk;

  llc_port_arbiter_if #(.NREQ(NR)) bus ();
`ifdef LLC_ARB_PERF_EN
  logic [NR*32-1:0] gcnt, scnt;
`endif

  llc_port_arbiter #(.NREQ(NR), .OUTSTANDING(OUTS)) dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .bus     (bus),
    .err_out (err)
`ifdef LLC_ARB_PERF_EN
    ,
    .grant_cnt_out (gcnt),
    .stall_cnt_out (scnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents, round-robin last winner, queue of read IDs.
  bit                    m_vld;
  logic [PADDR_BITS-1:0] m_addr;
  bit                    m_we;
  logic [LINE_W-1:0]     m_line;
  int                    m_rr;
  int                    m_q[$];
  bit                    m_err;
  bit                    auto_rsp;
  logic [NR-1:0]         last_rdy;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rline();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic idle_inputs();
    bus.req_valid_in = '0;
    bus.req_we_in    = '0;
    bus.req_addr_in  = '0;
    bus.req_line_in  = '0;
    bus.rsp_ready_in = '0;
    bus.lc_ready_in  = 1'b0;
    bus.lc_valid_in  = 1'b0;
    bus.lc_addr_in   = '0;
    bus.lc_line_in   = '0;
  endtask

  task automatic model_reset();
    m_vld  = 0;
    m_addr = '0;
    m_we   = 0;
    m_line = '0;
    m_rr   = NR - 1;
    m_q.delete();
    m_err  = 0;
  endtask

  task automatic zero_chk(input string pfx);
    chk({pfx, "_req_ready"}, bus.req_ready_out, '0);
    chk({pfx, "_lc_valid"},  bus.lc_valid_out,  '0);
    chk({pfx, "_lc_addr"},   bus.lc_addr_out,   '0);
    chk({pfx, "_lc_we"},     bus.lc_we_out,     '0);
    chk({pfx, "_lc_line"},   bus.lc_line_out,   '0);
    chk({pfx, "_rsp_valid"}, bus.rsp_valid_out, '0);
    chk({pfx, "_lc_ready"},  bus.lc_ready_out,  '0);
    chk({pfx, "_err"},       err,               '0);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic step();
    int            win;
    bit            can, eld;
    logic [NR-1:0] erdy, ersp;
    if (auto_rsp) bus.lc_valid_in = (m_q.size() > 0);
    @(negedge clk);
    win = -1;
    for (int i = 1; i <= NR; i++) begin
      int k = (m_rr + i) % NR;
      if (win < 0 && bus.req_valid_in[k] && (bus.req_we_in[k] || m_q.size() < OUTS)) win = k;
    end
    can  = !m_vld || bus.lc_ready_in;
    erdy = '0;
    if (win >= 0 && can) erdy[win] = 1'b1;
    ersp = '0;
    if (m_q.size() > 0) begin
      eld = bus.rsp_ready_in[m_q[0]];
      if (bus.lc_valid_in) ersp[m_q[0]] = 1'b1;
    end else begin
      eld = bus.lc_valid_in;
    end
    chk("req_ready", bus.req_ready_out, erdy);
    chk("lc_valid",  bus.lc_valid_out,  m_vld);
    if (m_vld) begin
      chk("lc_addr", bus.lc_addr_out, m_addr);
      chk("lc_we",   bus.lc_we_out,   m_we);
      chk("lc_line", bus.lc_line_out, m_line);
    end
    chk("rsp_valid", bus.rsp_valid_out, ersp);
    chk("lc_ready",  bus.lc_ready_out,  eld);
    chk("rsp_addr",  bus.rsp_addr_out,  bus.lc_addr_in);
    chk("rsp_line",  bus.rsp_line_out,  bus.lc_line_in);
    chk("err",       err,               m_err);
    last_rdy = bus.req_ready_out;
    if (bus.lc_valid_in && m_q.size() == 0) m_err = 1;
    if (bus.lc_valid_in && eld && m_q.size() > 0) void'(m_q.pop_front());
    if (win >= 0 && can) begin
      m_vld  = 1;
      m_addr = bus.req_addr_in[win];
      m_we   = bus.req_we_in[win];
      m_line = bus.req_line_in[win];
      m_rr   = win;
      if (!bus.req_we_in[win]) m_q.push_back(win);
    end else if (m_vld && bus.lc_ready_in) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    auto_rsp = 0;
    repeat (2) @(posedge clk);
    #1;
    zero_chk("reset");
    rst = 1'b0;

    // Single read from r0
    bus.lc_ready_in    = 1'b1;
    bus.rsp_ready_in   = '1;
    bus.req_valid_in   = 2'b01;
    bus.req_addr_in[0] = 19'h1A40;
    bus.req_line_in[0] = rline();
    step();
    chk("single_grant", last_rdy, 2'b01);
    chk("single_issue_v", bus.lc_valid_out, 1'b1);
    chk("single_issue_a", bus.lc_addr_out, 19'h1A40);
    bus.req_valid_in = '0;
    step();
    bus.lc_valid_in = 1'b1;
    bus.lc_addr_in  = 19'h1A40;
    bus.lc_line_in  = rline();
    #1;
    chk("single_rsp", bus.rsp_valid_out, 2'b01);
    step();
    bus.lc_valid_in = 1'b0;
    step();

    // Both requesters read every cycle: grants alternate
    auto_rsp         = 1;
    bus.req_valid_in = 2'b11;
    for (int i = 0; i < 8; i++) begin
      bus.req_addr_in[0] = PADDR_BITS'($urandom);
      bus.req_addr_in[1] = PADDR_BITS'($urandom);
      step();
      chk("alternate", last_rdy, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    bus.req_valid_in = '0;
    repeat (4) step();
    auto_rsp        = 0;
    bus.lc_valid_in = 1'b0;

    // LLC stalls with slot full
    bus.lc_ready_in    = 1'b0;
    bus.req_valid_in   = 2'b01;
    bus.req_addr_in[0] = 19'h2B00;
    step();
    bus.req_addr_in[0] = 19'h0777;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_ready", last_rdy, 2'b00);
      chk("stall_addr", bus.lc_addr_out, 19'h2B00);
    end
    bus.req_valid_in = '0;
    bus.lc_ready_in  = 1'b1;
    step();
    bus.lc_valid_in = 1'b1;
    step();
    bus.lc_valid_in = 1'b0;

    // Fill the ID FIFO with reads 1,0,1,0, then a writeback from r1 still gets through
    for (int i = 0; i < 4; i++) begin
      bus.req_valid_in = (i % 2 == 0) ? 2'b10 : 2'b01;
      bus.req_addr_in[i%2] = PADDR_BITS'(19'h100 + i);
      step();
    end
    bus.req_valid_in = 2'b11;
    bus.req_we_in    = 2'b10;
    step();
    chk("wb_grant", last_rdy, 2'b10);
    step();
    chk("rd_blocked", last_rdy[0], 1'b0);
    bus.req_valid_in = '0;
    bus.req_we_in    = '0;
    step();

    // Head is r1 but r1 not ready: no pop
    bus.lc_valid_in  = 1'b1;
    bus.rsp_ready_in = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_lc_ready", bus.lc_ready_out, 1'b0);
      chk("hold_rsp_valid", bus.rsp_valid_out, 2'b10);
    end
    bus.rsp_ready_in = 2'b11;
    repeat (4) step();
    bus.lc_valid_in = 1'b0;
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.req_valid_in = NR'($urandom);
      bus.req_we_in    = NR'($urandom);
      for (int r = 0; r < NR; r++) begin
        bus.req_addr_in[r] = PADDR_BITS'($urandom);
        bus.req_line_in[r] = rline();
      end
      bus.lc_ready_in  = ($urandom_range(0, 9) < 7);
      bus.rsp_ready_in = NR'($urandom);
      bus.lc_valid_in  = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      bus.lc_addr_in   = PADDR_BITS'($urandom);
      bus.lc_line_in   = rline();
      step();
    end
    bus.req_valid_in = '0;
    bus.lc_ready_in  = 1'b1;
    bus.rsp_ready_in = '1;
    auto_rsp         = 1;
    repeat (8) step();
    auto_rsp        = 0;
    bus.lc_valid_in = 1'b0;
    step();

    // Response with nothing outstanding
    bus.lc_valid_in = 1'b1;
    #1;
    chk("stray_drain", bus.lc_ready_out, 1'b1);
    step();
    chk("err_set", err, 1'b1);
    bus.lc_valid_in = 1'b0;
    repeat (3) step();
    chk("err_sticky", err, 1'b1);

    // Reset in the middle of a stall
    bus.lc_ready_in    = 1'b0;
    bus.req_valid_in   = 2'b01;
    bus.req_addr_in[0] = 19'h3C3C;
    step();
    step();
    rst             = 1'b1;
    bus.lc_valid_in = 1'b0;
    bus.lc_addr_in  = '0;
    bus.lc_line_in  = '0;
    @(posedge clk);
    #1;
    zero_chk("midrst");
    model_reset();
    idle_inputs();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
